core_bus_arbiter: RTL

- Shares the single core wishbone master port between two requesters: instruction fetch (port 0, IF) and memory access unit (port 1, MAU).
- Grants whole bus cycles: ownership is held from cyc assertion until cyc release.
- Round-robin or fixed priority on ties.
- Per-cycle watchdog returns err to the owner on a slave that never acknowledges.
- Sits between the core units and the external wishbone interconnect.

---
 rtl/i2d_core_defines.sv | 17 +
 rtl/core_bus_watchdog.sv | 43 ++++
 rtl/core_bus_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/i2d_core_defines.sv
// Shared core definitions used by the bus arbiter.
//   arb_state_t : arbiter FSM encoding
//   ARB_M_IF    : requester index of instruction fetch
//   ARB_M_MAU   : requester index of the memory access unit
package i2d_core_defines;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_OWN0,
    ARB_OWN1,
    ARB_DRAIN
  } arb_state_t;

  localparam int unsigned ARB_M_IF  = 0;
  localparam int unsigned ARB_M_MAU = 1;

endpackage

// File: rtl/core_bus_watchdog.sv
// Bus-cycle watchdog for the core arbiter.
//   clk, rst  : clock, asynchronous active-low reset
//   clear     : zero the counter (no owner, or slave responded)
//   count_en  : owner has a strobe driven or outstanding
//   expired   : this is the cycle the count reaches TIMEOUT; 0 if TIMEOUT=0
module core_bus_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturates at TIMEOUT so a stuck owner can never wrap back to a quiet count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && (cnt_q != CW'(TIMEOUT))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the cycle whose increment would hit TIMEOUT; an ack/err in that
  // same cycle arrives through clear and suppresses it.
  assign expired = (TIMEOUT != 0) && count_en && !clear &&
                   (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/core_bus_arbiter.sv
// Two-master wishbone arbiter for the core bus (port 0 = IF, port 1 = MAU).
// Grants whole bus cycles, one idle bubble between owners, watchdog error
// on a slave that never responds.
//   m_*      : per-master request side (cyc/stb/we/sel/adr/dat in; ack/err/stall/dat_r out)
//   s_*      : single slave-side wishbone port
//   gnt      : one-hot current owner (00 when idle)
module core_bus_arbiter
  import i2d_core_defines::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter bit          FAIR    = 1'b1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    m_cyc,
  input  logic [1:0]    m_stb,
  input  logic [1:0]    m_we,
  input  logic [3:0]    m_sel0,
  input  logic [3:0]    m_sel1,
  input  logic [AW-1:0] m_adr0,
  input  logic [AW-1:0] m_adr1,
  input  logic [DW-1:0] m_dat0,
  input  logic [DW-1:0] m_dat1,
  output logic [1:0]    m_ack,
  output logic [1:0]    m_err,
  output logic [1:0]    m_stall,
  output logic [DW-1:0] m_dat_r,
  output logic          s_cyc,
  output logic          s_stb,
  output logic          s_we,
  output logic [3:0]    s_sel,
  output logic [AW-1:0] s_adr,
  output logic [DW-1:0] s_dat_w,
  input  logic          s_ack,
  input  logic          s_err,
  input  logic          s_stall,
  input  logic [DW-1:0] s_dat_r,
  output logic [1:0]    gnt
);

  arb_state_t state_q;
  logic       owner_q;
  logic       last_q;
  logic       pend_q, pend_d;

  logic own;
  logic cur_cyc, cur_stb;
  logic pick;
  logic wd_clear, wd_count_en, timeout;

  assign own     = (state_q == ARB_OWN0) || (state_q == ARB_OWN1);
  assign cur_cyc = m_cyc[owner_q];
  assign cur_stb = m_stb[owner_q];

  // Tie-break: the master that did not own last, or MAU when not fair.
  assign pick = (m_cyc[ARB_M_IF] && m_cyc[ARB_M_MAU]) ? (FAIR ? ~last_q : 1'b1)
                                                      : m_cyc[ARB_M_MAU];

  // Outstanding strobe: accepted by the slave but not yet answered.
  assign pend_d = own & ((s_stb & ~s_stall) | (pend_q & ~(s_ack | s_err)));

  assign wd_clear    = ~own | s_ack | s_err;
  assign wd_count_en = own & (cur_stb | pend_q);

  core_bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (wd_clear),
    .count_en (wd_count_en),
    .expired  (timeout)
  );

  assign s_we    = owner_q ? m_we[ARB_M_MAU] : m_we[ARB_M_IF];
  assign s_sel   = owner_q ? m_sel1 : m_sel0;
  assign s_adr   = owner_q ? m_adr1 : m_adr0;
  assign s_dat_w = owner_q ? m_dat1 : m_dat0;
  assign m_dat_r = s_dat_r;

  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    m_ack   = '0;
    m_err   = '0;
    m_stall = '1;
    if (own) begin
      s_cyc            = cur_cyc & ~timeout;
      s_stb            = cur_stb & ~timeout;
      m_ack[owner_q]   = s_ack;
      m_err[owner_q]   = s_err | timeout;
      m_stall[owner_q] = s_stall;
    end
  end

  // The owner is still shown during DRAIN: it holds the bus until it drops cyc.
  assign gnt = (state_q == ARB_IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      unique case (state_q)
        ARB_IDLE: begin
          if (m_cyc[ARB_M_IF] || m_cyc[ARB_M_MAU]) begin
            owner_q <= pick;
            state_q <= pick ? ARB_OWN1 : ARB_OWN0;
          end
        end
        ARB_OWN0, ARB_OWN1: begin
          if (timeout) begin
            state_q <= ARB_DRAIN;
          end else if (!cur_cyc) begin
            state_q <= ARB_IDLE;
            last_q  <= owner_q;
          end
        end
        ARB_DRAIN: begin
          if (!cur_cyc) begin
            state_q <= ARB_IDLE;
            last_q  <= owner_q;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule
